mem_dp_param: RTL and testbench

MEM_DP_PARAM -- requirements
Module: mem_dp_param

---
 rtl/mem_dp_param.sv | 130 +++++++++++++
 tb/tb_mem_dp_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dp_param.sv
// Dual-write-port RAM with one registered read port, same-address collision counting and a whole-array zero-fill engine.
// Define MEM_DP_WRITE_BYPASS_EN to return freshly written data on a same-edge read/write hit (default: pre-write data).
module mem_dp_param #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_a,
    input  logic [AW-1:0] addr_wa,
    input  logic [DW-1:0] data_wa,
    input  logic          we_b,
    input  logic [AW-1:0] addr_wb,
    input  logic [DW-1:0] data_wb,
    input  logic          rd_en,
    input  logic          port_sel,
    input  logic          clr_req,
    output logic [DW-1:0] data_q,
    output logic          rd_valid,
    output logic          clr_busy,
    output logic          coll,
    output logic [7:0]    coll_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_cnt;
    logic [AW-1:0]   w_clr_cnt_nxt;
    logic [DW-1:0]   r_mem [0:(2**AW)-1];
    logic            w_busy;
    logic            w_coll;
    logic [AW-1:0]   w_rd_addr;
    logic [DW-1:0]   w_rd_data;

    assign w_busy    = (r_state == CLEAR);
    assign clr_busy  = w_busy;
    assign w_rd_addr = port_sel ? addr_wb : addr_wa;
    assign w_coll    = !w_busy && we_a && we_b && (addr_wa == addr_wb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            IDLE: begin
                if (clr_req) begin
                    w_state_nxt   = CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            CLEAR: begin
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (&r_clr_cnt) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: the array has no reset; clearing it is the job of the CLEAR state, and a reset must not touch it.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_clr_cnt] <= '0;
        end else begin
            // NOTE: with non-blocking assignments the last one wins, so port A takes priority on a collision.
            if (we_b) begin
                r_mem[addr_wb] <= data_wb;
            end
            if (we_a) begin
                r_mem[addr_wa] <= data_wa;
            end
        end
    end

`ifdef MEM_DP_WRITE_BYPASS_EN
    always_comb begin
        w_rd_data = r_mem[w_rd_addr];
        if (we_b && (addr_wb == w_rd_addr)) begin
            w_rd_data = data_wb;
        end
        if (we_a && (addr_wa == w_rd_addr)) begin
            w_rd_data = data_wa;
        end
    end
`else
    assign w_rd_data = r_mem[w_rd_addr];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            rd_valid <= 1'b0;
        end else if (!w_busy && rd_en) begin
            data_q   <= w_rd_data;
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

    // Collision pulse follows the colliding edge; the count saturates at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll     <= 1'b0;
            coll_cnt <= '0;
        end else begin
            coll <= w_coll;
            if (w_coll && (coll_cnt != 8'hFF)) begin
                coll_cnt <= coll_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_dp_param.sv
// Self-checking bench for mem_dp_param: directed scenarios plus random traffic against an array-based reference model.
module tb_mem_dp_param;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          we_a, we_b, rd_en, port_sel, clr_req;
    logic [AW-1:0] addr_wa, addr_wb;
    logic [DW-1:0] data_wa, data_wb;
    logic [DW-1:0] data_q;
    logic          rd_valid, clr_busy, coll;
    logic [7:0]    coll_cnt;

    mem_dp_param #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_a     (we_a),
        .addr_wa  (addr_wa),
        .data_wa  (data_wa),
        .we_b     (we_b),
        .addr_wb  (addr_wb),
        .data_wb  (data_wb),
        .rd_en    (rd_en),
        .port_sel (port_sel),
        .clr_req  (clr_req),
        .data_q   (data_q),
        .rd_valid (rd_valid),
        .clr_busy (clr_busy),
        .coll     (coll),
        .coll_cnt (coll_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] dq_m;
    logic          valid_m, coll_m, busy_m;
    int            cc_m;
    int            clr_addr_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data_q"},   32'(data_q),   32'(dq_m));
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(valid_m));
        check({tag, ".clr_busy"}, 32'(clr_busy), 32'(busy_m));
        check({tag, ".coll"},     32'(coll),     32'(coll_m));
        check({tag, ".coll_cnt"}, 32'(coll_cnt), 32'(cc_m));
    endtask

    task automatic reset_model();
        dq_m       = '0;
        valid_m    = 1'b0;
        coll_m     = 1'b0;
        busy_m     = 1'b0;
        cc_m       = 0;
        clr_addr_m = 0;
    endtask

    task automatic set_idle();
        we_a = 0; we_b = 0; rd_en = 0; port_sel = 0; clr_req = 0;
        addr_wa = '0; addr_wb = '0; data_wa = '0; data_wb = '0;
    endtask

    // Advance one clock: update the model from the current inputs, then compare after the edge.
    task automatic tick(input string tag);
        logic [AW-1:0] ra;
        logic [DW-1:0] old_val;
        if (busy_m) begin
            mem_m[clr_addr_m] = '0;
            clr_addr_m++;
            if (clr_addr_m == DEPTH) busy_m = 1'b0;
            valid_m = 1'b0;
            coll_m  = 1'b0;
        end else begin
            ra      = port_sel ? addr_wb : addr_wa;
            old_val = mem_m[ra];
            if (we_b) mem_m[addr_wb] = data_wb;
            if (we_a) mem_m[addr_wa] = data_wa;
            valid_m = rd_en;
            if (rd_en) begin
`ifdef MEM_DP_WRITE_BYPASS_EN
                dq_m = mem_m[ra];
`else
                dq_m = old_val;
`endif
            end
            coll_m = we_a && we_b && (addr_wa == addr_wb);
            if (coll_m && cc_m < 255) cc_m++;
            if (clr_req) begin
                busy_m     = 1'b1;
                clr_addr_m = 0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_idle();
        we_a = 1; addr_wa = a; data_wa = d;
        tick("wr_a");
    endtask

    task automatic rd(input logic sel, input logic [AW-1:0] a, input string tag);
        set_idle();
        rd_en = 1; port_sel = sel;
        if (sel) addr_wb = a; else addr_wa = a;
        tick(tag);
    endtask

    task automatic randomize_inputs(input int clr_odds);
        we_a     = 1'($urandom_range(0, 1));
        we_b     = 1'($urandom_range(0, 1));
        rd_en    = 1'($urandom_range(0, 1));
        port_sel = 1'($urandom_range(0, 1));
        clr_req  = ($urandom_range(0, clr_odds) == 0);
        addr_wa  = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
        addr_wb  = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
        data_wa  = 16'($urandom);
        data_wb  = 16'($urandom);
    endtask

    initial begin
        logic [DW-1:0] exp_rd [4];
        int n;

        set_idle();
        reset_model();
        rst_n = 0;
        #23;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1;
        tick("post_reset");

        // Bring the array to a known all-zero state, with ignored traffic during the fill.
        clr_req = 1;
        tick("clr0_start");
        n = 1;
        for (int i = 0; i < 300 && clr_busy; i++) begin
            randomize_inputs(3);
            tick("clr0_busy");
            if (clr_busy) n++;
        end
        check("clr0_len", 32'(n), 32'd256);
        set_idle();

        // Back-to-back reads on port A address
        wr_a(8'h00, 16'hAAAA);
        wr_a(8'h01, 16'h5555);
        wr_a(8'h02, 16'h1234);
        wr_a(8'h03, 16'hABCD);
        exp_rd = '{16'hAAAA, 16'h5555, 16'h1234, 16'hABCD};
        for (int i = 0; i < 4; i++) begin
            set_idle();
            rd_en = 1; addr_wa = 8'(i);
            tick("b2b_rd");
            check("b2b_data", 32'(data_q), 32'(exp_rd[i]));
            check("b2b_valid", 32'(rd_valid), 32'd1);
        end

        // Dual write to distinct addresses
        set_idle();
        we_a = 1; addr_wa = 8'h14; data_wa = 16'hDEAD;
        we_b = 1; addr_wb = 8'h15; data_wb = 16'hBEEF;
        tick("dual_wr");
        check("dual_wr_coll", 32'(coll), 32'd0);
        rd(1'b1, 8'h15, "rd_b15");
        check("rd_b15_val", 32'(data_q), 32'hBEEF);
        rd(1'b0, 8'h14, "rd_a14");
        check("rd_a14_val", 32'(data_q), 32'hDEAD);

        // Repeated same-address collisions drive the counter into saturation
        for (int i = 0; i < 300; i++) begin
            set_idle();
            we_a = 1; we_b = 1; addr_wa = 8'h20; addr_wb = 8'h20;
            data_wa = 16'h1111; data_wb = 16'h2222;
            tick("coll_rep");
            check("coll_pulse", 32'(coll), 32'd1);
        end
        set_idle();
        tick("coll_after");
        check("coll_drop", 32'(coll), 32'd0);
        rd(1'b0, 8'h20, "rd_coll");
        check("coll_mem", 32'(data_q), 32'h1111);
        check("coll_sat", 32'(coll_cnt), 32'd255);

        // Read-during-write on the same address
        set_idle();
        we_a = 1; addr_wa = 8'h30; data_wa = 16'hCAFE; rd_en = 1;
        tick("rdw");
`ifdef MEM_DP_WRITE_BYPASS_EN
        check("rdw_val", 32'(data_q), 32'hCAFE);
`else
        check("rdw_val", 32'(data_q), 32'h0000);
`endif

        // Full clear with ignored traffic, then spot reads
        set_idle();
        clr_req = 1;
        tick("clr1_start");
        n = 1;
        for (int i = 0; i < 300 && clr_busy; i++) begin
            randomize_inputs(2);
            tick("clr1_busy");
            if (clr_busy) n++;
        end
        check("clr1_len", 32'(n), 32'd256);
        rd(1'b0, 8'h00, "clr1_rd00");
        check("clr1_00", 32'(data_q), 32'h0);
        rd(1'b0, 8'h03, "clr1_rd03");
        check("clr1_03", 32'(data_q), 32'h0);
        rd(1'b1, 8'hFF, "clr1_rdFF");
        check("clr1_FF", 32'(data_q), 32'h0);

        // Reset in the middle of a clear
        wr_a(8'hFF, 16'h7777);
        set_idle();
        clr_req = 1;
        tick("clr2_start");
        set_idle();
        for (int i = 0; i < 100; i++) tick("clr2_busy");
        #2;
        rst_n = 0;
        #1;
        reset_model();
        check("rst_busy",  32'(clr_busy), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_coll",  32'(coll),     32'd0);
        check("rst_cnt",   32'(coll_cnt), 32'd0);
        check("rst_dq",    32'(data_q),   32'd0);
        @(negedge clk);
        rst_n = 1;
        tick("rst_release");
        rd(1'b0, 8'hFF, "rst_rdFF");
        check("rst_memFF", 32'(data_q), 32'h7777);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            randomize_inputs(150);
            tick("rand");
        end
        set_idle();
        for (int i = 0; i < 300 && busy_m; i++) tick("rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
